async_fifo: RTL and testbench
=============================

ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of write and read data.
REQ-002 Parameter DEPTH, default 16: number of entries; SHALL be a power of two, minimum 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: occupancy at or above which almost_full asserts.
REQ-004 Parameter AE_LEVEL, default 2: occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 wr_clk  input  1  sole clock; all write-port and read-port logic samples on its rising edge.
REQ-007 rstn  input  1  asynchronous, active-low reset.
REQ-008 wr_en  input  1  write request.
REQ-009 rd_en  input  1  read request.
REQ-010 wr_data  input  DATA_WIDTH  data to store.
REQ-011 rd_data  output  DATA_WIDTH  registered read data.
REQ-012 full / empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-013 almost_full / almost_empty  output  1 each  occupancy >= AF_LEVEL / occupancy <= AE_LEVEL.
REQ-014 overflow / underflow  output  1 each  one-cycle error pulses.
REQ-015 No rd_clk port SHALL exist; a bench interface that carries rd_clk SHALL leave it unconnected to the block.

Function
REQ-016 Storage SHALL be a circular buffer of DEPTH words with write and read pointers of log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty on wrap-around.
REQ-017 A write is accepted when wr_en=1 and full=0 at the clock edge: wr_data is stored at the write pointer and the write pointer increments.
REQ-018 A read is accepted when rd_en=1 and empty=0: the word at the read pointer is loaded into rd_data at that edge, giving one-cycle latency, and the read pointer increments.
REQ-019 rd_data SHALL hold its last value when no read is accepted.
REQ-020 Occupancy SHALL equal write pointer minus read pointer, modulo 2*DEPTH.
REQ-021 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered pointers, so they are valid in the cycle after each edge.
REQ-022 Simultaneous wr_en and rd_en with 0 < occupancy < DEPTH: both are accepted and occupancy is unchanged.
REQ-023 Simultaneous wr_en and rd_en when full: only the read is accepted, the write is dropped and overflow pulses.
REQ-024 Simultaneous wr_en and rd_en when empty: only the write is accepted, rd_data is unchanged and underflow pulses.
REQ-025 overflow SHALL be 1 for exactly the cycle after an edge where wr_en=1 and full=1, and 0 otherwise; a dropped write SHALL NOT alter memory or pointers.
REQ-026 underflow SHALL be 1 for exactly the cycle after an edge where rd_en=1 and empty=1, and 0 otherwise; a rejected read SHALL NOT alter pointers or rd_data.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL preserve FIFO order with no lost or duplicated data.

Reset
REQ-028 While rstn=0, regardless of clock: pointers=0, rd_data=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
REQ-029 Reset asserted mid-operation SHALL discard all contents; memory array contents need not be cleared.
REQ-030 The first accepted operation SHALL occur on the first rising edge after rstn deasserts.

Structure
REQ-031 Package fifo_pack SHALL hold DATA_WIDTH, DEPTH, AF_LEVEL, AE_LEVEL defaults, the derived pointer width, and the reset-pulse duration constant RST_TIME used by benches.
REQ-032 The memory array SHALL be a sub-module fifo_mem: synchronous write, read address registered into rd_data.
REQ-033 Interface fifo_intf SHALL bundle wr_enbl, rd_enbl, wr_data, rd_data and the six flags, with ports wr_clk and rstn.

Verification
REQ-034 Reset, then 16 writes of 0x00..0x0F -> full=1 after the 16th edge; almost_full=1 from occupancy 14.
REQ-035 Drain the 16 entries -> rd_data 0x00..0x0F in order, each one cycle after its rd_en edge; empty=1 after the last read.
REQ-036 Write 0xAA while full -> overflow=1 for one cycle, and a later read order excludes 0xAA.
REQ-037 rd_en while empty -> underflow=1 for one cycle and rd_data unchanged.
REQ-038 At occupancy 8, wr_en and rd_en together for 20 cycles with incrementing data -> occupancy stays 8, output order correct across pointer wrap.
REQ-039 Assert rstn=0 mid-burst at occupancy 5 -> all outputs at reset values immediately; empty=1 with no clock edge required.

Source files
------------

// File: rtl/fifo_pack.sv
// Shared defaults and helpers for the single-clock FIFO slice.
package fifo_pack;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_AF_LEVEL   = DEF_DEPTH - 2;
    localparam int DEF_AE_LEVEL   = 2;
    localparam int RST_TIME       = 23;

    // Extra MSB separates full from empty when the pointers wrap.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int PTR_WIDTH = ptr_width(DEF_DEPTH);
endpackage

// File: rtl/fifo_intf.sv
// Signal bundle between a bench and async_fifo; carries no read clock.
interface fifo_intf
    import fifo_pack::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)(
    input logic wr_clk,
    input logic rstn
);
    logic                  wr_enbl;
    logic                  rd_enbl;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    modport dut (
        input  wr_clk, rstn, wr_enbl, rd_enbl, wr_data,
        output rd_data, full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write, read word registered into rd_data.
module fifo_mem
    import fifo_pack::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 4
)(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Array is left uncleared on reset; only the output register resets.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/async_fifo.sv
// Single-clock circular-buffer FIFO with occupancy flags and error pulses.
module async_fifo
    import fifo_pack::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
)(
    input  logic                  wr_clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] occupancy;
    logic          wr_accept;
    logic          rd_accept;

    // Flags decode straight from the registered pointers, so reset clears them at once.
    always_comb begin
        occupancy    = wr_ptr - rd_ptr;
        full         = (occupancy == PW'(DEPTH));
        empty        = (occupancy == '0);
        almost_full  = (occupancy >= PW'(AF_LEVEL));
        almost_empty = (occupancy <= PW'(AE_LEVEL));
        wr_accept    = wr_en && !full;
        rd_accept    = rd_en && !empty;
    end

    always_ff @(posedge wr_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_mem (
        .clk     (wr_clk),
        .rstn    (rstn),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_async_fifo.sv
// Bench for async_fifo: directed and random traffic against a queue model.
module tb_async_fifo;
    import fifo_pack::*;

    localparam int DW  = DEF_DATA_WIDTH;
    localparam int D   = DEF_DEPTH;
    localparam int AFL = DEF_AF_LEVEL;
    localparam int AEL = DEF_AE_LEVEL;

    logic wr_clk = 1'b0;
    logic rstn   = 1'b0;

    fifo_intf #(.DATA_WIDTH(DW)) bus (.wr_clk(wr_clk), .rstn(rstn));

    async_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (D),
        .AF_LEVEL   (AFL),
        .AE_LEVEL   (AEL)
    ) dut (
        .wr_clk       (wr_clk),
        .rstn         (rstn),
        .wr_en        (bus.wr_enbl),
        .rd_en        (bus.rd_enbl),
        .wr_data      (bus.wr_data),
        .rd_data      (bus.rd_data),
        .full         (bus.full),
        .empty        (bus.empty),
        .almost_full  (bus.almost_full),
        .almost_empty (bus.almost_empty),
        .overflow     (bus.overflow),
        .underflow    (bus.underflow)
    );

    always #5 wr_clk = ~wr_clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_rd  = '0;
    logic          exp_ovf = 1'b0;
    logic          exp_udf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int occ;
        occ = model_q.size();
        chk({tag, ":rd_data"},      32'(bus.rd_data),     32'(exp_rd));
        chk({tag, ":full"},         32'(bus.full),        32'(occ == D));
        chk({tag, ":empty"},        32'(bus.empty),       32'(occ == 0));
        chk({tag, ":almost_full"},  32'(bus.almost_full), 32'(occ >= AFL));
        chk({tag, ":almost_empty"}, 32'(bus.almost_empty),32'(occ <= AEL));
        chk({tag, ":overflow"},     32'(bus.overflow),    32'(exp_ovf));
        chk({tag, ":underflow"},    32'(bus.underflow),   32'(exp_udf));
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_rd  = '0;
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
    endtask

    // One clock: drive, let the edge happen, update the model, check #1 later.
    task automatic step(input logic we, input logic re, input logic [DW-1:0] wd, input string tag);
        bit was_full;
        bit was_empty;
        bus.wr_enbl = we;
        bus.rd_enbl = re;
        bus.wr_data = wd;
        @(posedge wr_clk);
        was_full  = (model_q.size() == D);
        was_empty = (model_q.size() == 0);
        if (re && !was_empty) exp_rd = model_q.pop_front();
        if (we && !was_full) model_q.push_back(wd);
        exp_ovf = we && was_full;
        exp_udf = re && was_empty;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [DW-1:0] held;
        logic [DW-1:0] cnt;
        bus.wr_enbl = 1'b0;
        bus.rd_enbl = 1'b0;
        bus.wr_data = '0;
        model_reset();

        // Reset state, with clock running
        #(RST_TIME);
        check_all("reset");
        @(negedge wr_clk);
        rstn = 1'b1;

        // Fill 0x00..0x0F, then write 0xAA while full
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, DW'(i), "fill");
        chk("full_after_16", 32'(bus.full), 32'd1);
        step(1'b1, 1'b0, 8'hAA, "ovf");
        chk("ovf_pulse", 32'(bus.overflow), 32'd1);
        step(1'b0, 1'b0, '0, "ovf_clear");
        chk("ovf_one_cycle", 32'(bus.overflow), 32'd0);

        // Drain and verify order excludes 0xAA
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, '0, "drain");
            chk("drain_order", 32'(bus.rd_data), 32'(i));
        end

        // Read while empty
        held = bus.rd_data;
        step(1'b0, 1'b1, '0, "udf");
        chk("udf_pulse", 32'(bus.underflow), 32'd1);
        chk("udf_hold", 32'(bus.rd_data), 32'(held));
        step(1'b1, 1'b1, 8'h5C, "udf_wr");
        chk("udf_wr_hold", 32'(bus.rd_data), 32'(held));
        step(1'b0, 1'b1, '0, "udf_wr_read");
        chk("udf_wr_data", 32'(bus.rd_data), 32'h5C);

        // Hold occupancy at 8 across pointer wrap
        cnt = 8'h40;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, cnt, "to8");
            cnt++;
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, cnt, "steady8");
            cnt++;
            chk("occ8", 32'(model_q.size()), 32'd8);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom_range(0, 255)), "rand");
        end

        // Mid-burst reset at occupancy 5
        while (model_q.size() > 0) step(1'b0, 1'b1, '0, "flush");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 255)), "to5");
        bus.wr_enbl = 1'b1;
        bus.wr_data = 8'h33;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        @(posedge wr_clk);
        #1;
        check_all("mid_reset_held");
        bus.wr_enbl = 1'b0;
        @(negedge wr_clk);
        rstn = 1'b1;
        step(1'b1, 1'b0, 8'h77, "post_reset_wr");
        step(1'b0, 1'b1, '0, "post_reset_rd");
        chk("post_reset_data", 32'(bus.rd_data), 32'h77);
        for (int i = 0; i < 100; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 DW'($urandom_range(0, 255)), "rand2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
